// File: rtl/mips_fetch_queue_pkg.sv
// Shared constants and types for the MIPS instruction-fetch queue.
// Holds the instruction width, the default reset PC and the queue entry layout.
package mips_fetch_queue_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fqEntry_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mips_fetch_queue_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handshake and redirect.
// master = fetch unit, slave = its environment (memory, decode, branch unit).
interface mips_fetch_queue_if #(
    parameter int IM_AW = 10,
    parameter int OCC_W = 3
);
    import mips_fetch_queue_pkg::*;

    logic               im_req;
    logic [IM_AW-1:0]   im_addr;
    logic               im_ready;
    logic               im_rvalid;
    logic [INSTR_W-1:0] im_rdata;

    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [31:0]        if_pc;
    logic               if_ready;

    logic               redirect;
    logic [31:0]        redirect_pc;

    logic [OCC_W-1:0]   occupancy;
    logic               proto_err;

    modport master (
        output im_req, im_addr, if_valid, if_instr, if_pc, occupancy, proto_err,
        input  im_ready, im_rvalid, im_rdata, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  im_req, im_addr, if_valid, if_instr, if_pc, occupancy, proto_err,
        output im_ready, im_rvalid, im_rdata, if_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/mips_fetch_queue_mem.sv
// Fetch-queue storage: pc written at allocate, instruction written at fill,
// head entry read combinationally. Filled bits live in the parent.
module fetch_queue_mem
    import mips_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               wrAEn,
    input  logic [PTR_W-1:0]   wrAIdx,
    input  logic [31:0]        wrAPc,
    input  logic               wrBEn,
    input  logic [PTR_W-1:0]   wrBIdx,
    input  logic [INSTR_W-1:0] wrBInstr,
    input  logic [PTR_W-1:0]   rdIdx,
    output fqEntry_t           rdEntry
);

    logic [31:0]        pcArr    [DEPTH];
    logic [INSTR_W-1:0] instrArr [DEPTH];

    always_ff @(posedge clk) begin
        if (wrAEn) pcArr[wrAIdx] <= wrAPc;
        if (wrBEn) instrArr[wrBIdx] <= wrBInstr;
    end

    assign rdEntry = {pcArr[rdIdx], instrArr[rdIdx]};

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch unit: owns the PC, keeps up to DEPTH requests in flight to a
// variable-latency memory and hands instructions to decode in order.
module mips_fetch_queue
    import mips_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          IM_AW    = 10,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic CLK,
    input  logic RST,
    mips_fetch_queue_if.master bus
);

    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [31:0]      fetchPc;
    ptr_t             headPtr, tailPtr, fillPtr;
    cnt_t             allocCnt, pendCnt, dropCnt;
    logic [DEPTH-1:0] filled, filledNext;
    logic             protoErr;
    fqEntry_t         headEntry;

    logic [CNT_W:0]   credUsed, flushOwed;
    cnt_t             flushDrop;
    logic             issue, accept, consume, headVld;
    logic             rspDrop, rspFill, rspOrphan;

    // Credits count both live entries and stale responses still owed to us.
    assign credUsed  = {1'b0, allocCnt} + {1'b0, dropCnt};
    assign issue     = !bus.redirect && (credUsed < DEPTH_C);
    assign accept    = issue && bus.im_ready;
    assign headVld   = filled[headPtr];
    assign consume   = headVld && !bus.redirect && bus.if_ready;

    assign rspDrop   = bus.im_rvalid && (dropCnt != '0);
    assign rspFill   = bus.im_rvalid && (dropCnt == '0) && (pendCnt != '0);
    assign rspOrphan = bus.im_rvalid && (dropCnt == '0) && (pendCnt == '0);

    // Everything unanswered at flush time becomes stale, less whatever lands now.
    assign flushOwed = {1'b0, dropCnt} + {1'b0, pendCnt};
    always_comb begin
        flushDrop = '0;
        if (flushOwed != '0)
            flushDrop = cnt_t'(flushOwed - (CNT_W+1)'(bus.im_rvalid));
    end

    always_comb begin
        filledNext = filled;
        if (rspFill) filledNext[fillPtr] = 1'b1;
        if (consume) filledNext[headPtr] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetchPc  <= RESET_PC;
            headPtr  <= '0;
            tailPtr  <= '0;
            fillPtr  <= '0;
            allocCnt <= '0;
            pendCnt  <= '0;
            dropCnt  <= '0;
            filled   <= '0;
            protoErr <= 1'b0;
        end else begin
            if (rspOrphan) protoErr <= 1'b1;
            if (bus.redirect) begin
                fetchPc  <= wordAlign(bus.redirect_pc);
                headPtr  <= '0;
                tailPtr  <= '0;
                fillPtr  <= '0;
                allocCnt <= '0;
                pendCnt  <= '0;
                filled   <= '0;
                dropCnt  <= flushDrop;
            end else begin
                if (accept) begin
                    fetchPc <= fetchPc + 32'd4;
                    tailPtr <= tailPtr + ptr_t'(1);
                end
                if (rspFill) fillPtr <= fillPtr + ptr_t'(1);
                if (consume) headPtr <= headPtr + ptr_t'(1);
                allocCnt <= allocCnt + cnt_t'(accept) - cnt_t'(consume);
                pendCnt  <= pendCnt + cnt_t'(accept) - cnt_t'(rspFill);
                dropCnt  <= dropCnt - cnt_t'(rspDrop);
                filled   <= filledNext;
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk      (CLK),
        .wrAEn    (accept),
        .wrAIdx   (tailPtr),
        .wrAPc    (fetchPc),
        .wrBEn    (rspFill && !bus.redirect),
        .wrBIdx   (fillPtr),
        .wrBInstr (bus.im_rdata),
        .rdIdx    (headPtr),
        .rdEntry  (headEntry)
    );

    assign bus.im_req    = issue;
    assign bus.im_addr   = fetchPc[IM_AW+1:2];
    assign bus.if_valid  = headVld && !bus.redirect;
    assign bus.if_instr  = headEntry.instr;
    assign bus.if_pc     = headEntry.pc;
    assign bus.occupancy = allocCnt;
    assign bus.proto_err = protoErr;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue with an in-order variable-latency memory model.
module tb_mips_fetch_queue;

    logic CLK;
    logic RST;
    logic memRv, injRv;
    logic [31:0] memRdata;

    int nCmp = 0;
    int nBad = 0;
    int lat  = 1;
    int cycCnt = 0;
    int nAcc, n;

    typedef struct {
        int        due;
        logic [9:0] addr;
    } rsp_t;
    rsp_t rspQ[$];
    bit         accFlag, rvFlag;
    logic [9:0] accAddr;

    int occT[6] = '{0, 1, 2, 2, 2, 2};
    int vldT[6] = '{0, 0, 1, 1, 1, 1};

    mips_fetch_queue_if #(.IM_AW(10), .OCC_W(3)) bus ();

    mips_fetch_queue #(
        .DEPTH    (4),
        .IM_AW    (10),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    assign bus.im_rvalid = memRv | injRv;
    assign bus.im_rdata  = memRdata;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mkInstr(input logic [9:0] a);
        return 32'hC0DE_0000 | {22'h0, a};
    endfunction

    // Memory model: sample handshakes mid-cycle, answer in order after lat cycles.
    always @(negedge CLK) begin
        accFlag = RST && bus.im_req && bus.im_ready;
        accAddr = bus.im_addr;
        rvFlag  = memRv;
    end

    always @(posedge CLK) begin
        rsp_t r;
        if (!RST) rspQ.delete();
        else begin
            if (rvFlag && rspQ.size() > 0) void'(rspQ.pop_front());
            if (accFlag) begin
                r.due  = cycCnt + lat;
                r.addr = accAddr;
                rspQ.push_back(r);
            end
        end
        cycCnt++;
        #1;
        if (rspQ.size() > 0 && rspQ[0].due <= cycCnt) begin
            memRv    = 1'b1;
            memRdata = mkInstr(rspQ[0].addr);
        end else begin
            memRv    = 1'b0;
            memRdata = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic resetDut();
        bus.redirect = 1'b0;
        RST = 1'b0;
        step();
        step();
    endtask

    task automatic waitVld(input int maxCyc, output int waited);
        waited = 0;
        @(negedge CLK);
        while (!bus.if_valid && waited < maxCyc) begin
            step();
            waited++;
            @(negedge CLK);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b0;
        memRv = 1'b0;
        injRv = 1'b0;
        memRdata = '0;
        bus.im_ready = 1'b1;
        bus.if_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        // Reset state
        step();
        @(negedge CLK);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_im_addr", bus.im_addr, 0);
        chk("rst_proto_err", bus.proto_err, 0);
        step();

        // Streaming at latency 1 with decode always ready
        bus.if_ready = 1'b1;
        RST = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk($sformatf("t1_im_req_c%0d", k), bus.im_req, 1);
            chk($sformatf("t1_im_addr_c%0d", k), bus.im_addr, k);
            chk($sformatf("t1_occ_c%0d", k), bus.occupancy, occT[k]);
            chk($sformatf("t1_vld_c%0d", k), bus.if_valid, vldT[k]);
            if (vldT[k] != 0) begin
                chk($sformatf("t1_pc_c%0d", k), bus.if_pc, 32'(4 * (k - 2)));
                chk($sformatf("t1_instr_c%0d", k), bus.if_instr, mkInstr(10'(k - 2)));
            end
            step();
        end

        // Decode stalled: queue fills to DEPTH and stops requesting
        resetDut();
        bus.if_ready = 1'b0;
        RST = 1'b1;
        nAcc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.im_req && bus.im_ready) nAcc++;
            step();
        end
        chk("t2_req_count", nAcc, 4);
        @(negedge CLK);
        chk("t2_full_req", bus.im_req, 0);
        chk("t2_full_occ", bus.occupancy, 4);
        chk("t2_full_vld", bus.if_valid, 1);
        chk("t2_full_pc", bus.if_pc, 32'h0);
        step();
        bus.if_ready = 1'b1;
        @(negedge CLK);
        chk("t2_credit_reg_req", bus.im_req, 0);
        chk("t2_consume_pc", bus.if_pc, 32'h0);
        step();
        bus.if_ready = 1'b0;
        @(negedge CLK);
        chk("t2_credit_back_req", bus.im_req, 1);
        chk("t2_after_occ", bus.occupancy, 3);
        chk("t2_after_pc", bus.if_pc, 32'h4);
        step();

        // Latency 3, two in flight, then redirect to 0x100
        resetDut();
        lat = 3;
        bus.if_ready = 1'b1;
        bus.im_ready = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        chk("t3_first_addr", bus.im_addr, 0);
        step();
        step();
        bus.im_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        @(negedge CLK);
        chk("t3_redir_req", bus.im_req, 0);
        chk("t3_redir_vld", bus.if_valid, 0);
        step();
        bus.redirect = 1'b0;
        bus.im_ready = 1'b1;
        @(negedge CLK);
        chk("t3_post_req", bus.im_req, 1);
        chk("t3_post_addr", bus.im_addr, 32'h40);
        step();
        waitVld(12, n);
        chk("t3_wait_cycles", n, 3);
        chk("t3_first_pc", bus.if_pc, 32'h100);
        chk("t3_first_instr", bus.if_instr, 32'hC0DE_0040);
        step();

        // Redirect coinciding with a consume attempt at head pc 0x8
        resetDut();
        lat = 1;
        bus.if_ready = 1'b0;
        RST = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.if_ready = 1'b1;
        @(negedge CLK);
        chk("t4_a_vld", bus.if_valid, 1);
        chk("t4_a_pc", bus.if_pc, 32'h0);
        chk("t4_a_req", bus.im_req, 0);
        step();
        @(negedge CLK);
        chk("t4_b_pc", bus.if_pc, 32'h4);
        chk("t4_b_req", bus.im_req, 1);
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h203;
        @(negedge CLK);
        chk("t4_x_head_pc", bus.if_pc, 32'h8);
        chk("t4_x_vld", bus.if_valid, 0);
        chk("t4_x_req", bus.im_req, 0);
        chk("t4_x_occ", bus.occupancy, 3);
        step();
        bus.redirect = 1'b0;
        @(negedge CLK);
        chk("t4_post_addr", bus.im_addr, 32'h80);
        chk("t4_post_occ", bus.occupancy, 0);
        chk("t4_post_vld", bus.if_valid, 0);
        step();
        waitVld(10, n);
        chk("t4_wait_cycles", n, 1);
        chk("t4_new_pc", bus.if_pc, 32'h200);
        chk("t4_new_instr", bus.if_instr, 32'hC0DE_0080);
        step();

        // Two-cycle redirect (last target wins) to 0xFFFF_FFFC, then PC wrap
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h500;
        @(negedge CLK);
        chk("t5_r1_req", bus.im_req, 0);
        step();
        bus.redirect_pc = 32'hFFFF_FFFE;
        @(negedge CLK);
        chk("t5_r2_vld", bus.if_valid, 0);
        step();
        bus.redirect = 1'b0;
        @(negedge CLK);
        chk("t5_p0_addr", bus.im_addr, 32'h3FF);
        chk("t5_p0_req", bus.im_req, 1);
        step();
        @(negedge CLK);
        chk("t5_wrap_addr", bus.im_addr, 32'h0);
        step();
        waitVld(12, n);
        chk("t5_top_pc", bus.if_pc, 32'hFFFF_FFFC);
        chk("t5_top_instr", bus.if_instr, 32'hC0DE_03FF);
        step();
        @(negedge CLK);
        chk("t5_wrap_vld", bus.if_valid, 1);
        chk("t5_wrap_pc", bus.if_pc, 32'h0);
        chk("t5_wrap_instr", bus.if_instr, 32'hC0DE_0000);
        step();

        // Drain, then inject an orphan response
        bus.im_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        @(negedge CLK);
        chk("t6_drained_occ", bus.occupancy, 0);
        chk("t6_drained_vld", bus.if_valid, 0);
        chk("t6_pre_err", bus.proto_err, 0);
        step();
        injRv = 1'b1;
        @(negedge CLK);
        chk("t6_inj_err_reg", bus.proto_err, 0);
        step();
        injRv = 1'b0;
        @(negedge CLK);
        chk("t6_err_set", bus.proto_err, 1);
        chk("t6_err_occ", bus.occupancy, 0);
        for (int i = 0; i < 3; i++) step();
        @(negedge CLK);
        chk("t6_err_sticky", bus.proto_err, 1);
        step();
        RST = 1'b0;
        #1;
        chk("t6_async_rst_err", bus.proto_err, 0);
        chk("t6_async_rst_occ", bus.occupancy, 0);
        chk("t6_async_rst_vld", bus.if_valid, 0);
        chk("t6_async_rst_addr", bus.im_addr, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
